// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Architectural register bank: DEPTH words of WIDTH bits, one synchronous
//   write port and two independent registered read ports. Each entry carries
//   a "written since reset" flag that is returned alongside the read data.
//
// Parameters
//   WIDTH    bits per word (1..64)
//   DEPTH    number of entries (2..256, need not be a power of two)
//   AW       address width, derived from DEPTH (do not override)
//   ZERO_REG when 1, entry 0 reads as constant zero (valid) and ignores writes
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset (clears data and flags)
//   we, waddr, wdata    write port
//   re_a, raddr_a       read port A request
//   rdata_a, rvalid_a   read port A registered data / written flag
//   re_b, raddr_b       read port B request
//   rdata_b, rvalid_b   read port B registered data / written flag
//
// Build option
//   REG_FILE_BYPASS_EN  defined: write-first (a read of the address being
//                       written at the same edge returns wdata, rvalid=1).
//                       undefined: read-first (returns pre-write contents).
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    // One extra bit so DEPTH itself is representable when DEPTH = 2**AW.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] flag_reg;

    logic             wr_accept;
    logic [DEPTH-1:0] wr_hit;

    // A write is accepted only for an in-range address that is not the
    // hard-wired zero entry; the same qualifier gates the bypass path.
    assign wr_accept = we
                       && ({1'b0, waddr} < DEPTH_L)
                       && !(ZERO_REG && (waddr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi] = wr_accept && (waddr == AW'(gi));
        end
    endgenerate

    // Storage is cleared by reset, so it is kept in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            flag_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    mem_reg[i]  <= wdata;
                    flag_reg[i] <= 1'b1;
                end
            end
        end
    end

    // Per-port request vectors so both read ports share one generate body.
    logic [1:0]    re_v;
    logic [AW-1:0] raddr_v [2];

    assign re_v       = {re_b, re_a};
    assign raddr_v[0] = raddr_a;
    assign raddr_v[1] = raddr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] data_reg;
            logic [WIDTH-1:0] data_next;
            logic             valid_reg;
            logic             valid_next;
            logic [AW-1:0]    addr;
            logic             in_range;

            assign addr     = raddr_v[gi];
            assign in_range = ({1'b0, addr} < DEPTH_L);

            always_comb begin
                data_next  = data_reg;
                valid_next = valid_reg;
                if (re_v[gi]) begin
                    if (ZERO_REG && (addr == '0)) begin
                        // Constant zero counts as architecturally valid.
                        data_next  = '0;
                        valid_next = 1'b1;
                    end else if (!in_range) begin
                        data_next  = '0;
                        valid_next = 1'b0;
`ifdef REG_FILE_BYPASS_EN
                    end else if (wr_accept && (waddr == addr)) begin
                        data_next  = wdata;
                        valid_next = 1'b1;
`endif
                    end else begin
                        data_next  = mem_reg[addr];
                        valid_next = flag_reg[addr];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    data_reg  <= data_next;
                    valid_reg <= valid_next;
                end
            end
        end
    endgenerate

    assign rdata_a  = g_port[0].data_reg;
    assign rvalid_a = g_port[0].valid_reg;
    assign rdata_b  = g_port[1].data_reg;
    assign rvalid_b = g_port[1].valid_reg;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Drives three reg_file instances from the same stimulus:
//     k=0: WIDTH=8 DEPTH=8 ZERO_REG=1
//     k=1: WIDTH=8 DEPTH=8 ZERO_REG=0
//     k=2: WIDTH=8 DEPTH=6 ZERO_REG=1
//   A directed vector table (expectations for k=0), a few hand sequences for
//   the other configurations, then random traffic checked against an
//   array-based reference model for all three instances.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic       clk;
    logic       rst;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;

    logic [7:0] rdata_a_d  [3];
    logic       rvalid_a_d [3];
    logic [7:0] rdata_b_d  [3];
    logic       rvalid_b_d [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            reg_file #(
                .WIDTH   (8),
                .DEPTH   ((gi == 2) ? 6 : 8),
                .ZERO_REG((gi == 1) ? 1'b0 : 1'b1)
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .we      (we),
                .waddr   (waddr),
                .wdata   (wdata),
                .re_a    (re_a),
                .raddr_a (raddr_a),
                .rdata_a (rdata_a_d[gi]),
                .rvalid_a(rvalid_a_d[gi]),
                .re_b    (re_b),
                .raddr_b (raddr_b),
                .rdata_b (rdata_b_d[gi]),
                .rvalid_b(rvalid_b_d[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         depth_m [3] = '{8, 8, 6};
    bit         zr_m    [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] m_mem   [3][8];
    bit         m_flg   [3][8];
    logic [7:0] m_rd    [3][2];
    bit         m_rv    [3][2];
    bit         model_ok = 1'b0;

    // Applies one clock edge worth of the rules to every configuration.
    task automatic model_edge();
        bit         acc;
        bit         rq;
        int         a;
        int         w;
        bit         bypass;
`ifdef REG_FILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        w = int'(waddr);
        for (int k = 0; k < 3; k++) begin
            acc = we && (w < depth_m[k]) && !(zr_m[k] && w == 0);
            for (int p = 0; p < 2; p++) begin
                rq = (p == 0) ? re_a : re_b;
                a  = (p == 0) ? int'(raddr_a) : int'(raddr_b);
                if (rst) begin
                    m_rd[k][p] = 8'h00;
                    m_rv[k][p] = 1'b0;
                end else if (rq) begin
                    if (zr_m[k] && a == 0) begin
                        m_rd[k][p] = 8'h00;
                        m_rv[k][p] = 1'b1;
                    end else if (a >= depth_m[k]) begin
                        m_rd[k][p] = 8'h00;
                        m_rv[k][p] = 1'b0;
                    end else if (bypass && acc && a == w) begin
                        m_rd[k][p] = wdata;
                        m_rv[k][p] = 1'b1;
                    end else begin
                        m_rd[k][p] = m_mem[k][a];
                        m_rv[k][p] = m_flg[k][a];
                    end
                end
            end
            if (rst) begin
                for (int e = 0; e < 8; e++) begin
                    m_mem[k][e] = 8'h00;
                    m_flg[k][e] = 1'b0;
                end
            end else if (acc) begin
                m_mem[k][w] = wdata;
                m_flg[k][w] = 1'b1;
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    task automatic model_compare();
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_c%0d_rdata_a", k), 32'(rdata_a_d[k]), 32'(m_rd[k][0]));
                chk($sformatf("model_c%0d_rvalid_a", k), 32'(rvalid_a_d[k]), 32'(m_rv[k][0]));
                chk($sformatf("model_c%0d_rdata_b", k), 32'(rdata_b_d[k]), 32'(m_rd[k][1]));
                chk($sformatf("model_c%0d_rvalid_b", k), 32'(rvalid_b_d[k]), 32'(m_rv[k][1]));
            end
        end
    endtask

    // One clock: inputs are already driven; sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        model_compare();
        $display("cyc %0d rst=%0d we=%0d wa=%0d wd=%02h | A re=%0d ad=%0d -> %02h/%0d | B re=%0d ad=%0d -> %02h/%0d",
                 cyc, rst, we, waddr, wdata, re_a, raddr_a, rdata_a_d[0], rvalid_a_d[0],
                 re_b, raddr_b, rdata_b_d[0], rvalid_b_d[0]);
    endtask

    task automatic drive(input bit r, input bit w, input int wa, input int wd,
                         input bit ra, input int aa, input bit rb, input int ab);
        rst     = r;
        we      = w;
        waddr   = 3'(wa);
        wdata   = 8'(wd);
        re_a    = ra;
        raddr_a = 3'(aa);
        re_b    = rb;
        raddr_b = 3'(ab);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         we;
        int         waddr;
        int         wdata;
        bit         re_a;
        int         raddr_a;
        bit         re_b;
        int         raddr_b;
        logic [7:0] ea;
        bit         va;
        logic [7:0] eb;
        bit         vb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit w, input int wa, input int wd,
                       input bit ra, input int aa, input bit rb, input int ab,
                       input int ea, input bit va, input int eb, input bit vb);
        vec_t t;
        t.rst = r; t.we = w; t.waddr = wa; t.wdata = wd;
        t.re_a = ra; t.raddr_a = aa; t.re_b = rb; t.raddr_b = ab;
        t.ea = 8'(ea); t.va = va; t.eb = 8'(eb); t.vb = vb;
        vecs.push_back(t);
    endtask

    initial begin
        int rdw;
        int wa;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

`ifdef REG_FILE_BYPASS_EN
        rdw = 'h22;
`else
        rdw = 'h11;
`endif
        // reset for two cycles, then read every entry on both ports
        add(1, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 0, 0, 0, 1, i, 1, i,  0, (i == 0), 0, (i == 0));
        end
        // write / read-back
        add(0, 1, 3, 'hA5, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 7, 'h3C, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 0, 0,    1, 3, 1, 7,   'hA5, 1, 'h3C, 1);
        // zero register
        add(0, 1, 0, 'hFF, 0, 0, 0, 0,   'hA5, 1, 'h3C, 1);
        add(0, 0, 0, 0,    1, 0, 1, 0,   0, 1, 0, 1);
        // read-during-write on entry 5
        add(0, 1, 5, 'h11, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 1, 5, 'h22, 1, 5, 0, 0,   rdw, 1, 0, 1);
        add(0, 0, 0, 0,    1, 5, 0, 0,   'h22, 1, 0, 1);
        // address 6 (in range here, out of range on the 6-entry instance)
        add(0, 1, 6, 'h77, 0, 0, 0, 0,   'h22, 1, 0, 1);
        add(0, 0, 0, 0,    1, 6, 1, 5,   'h77, 1, 'h22, 1);
        // reset coinciding with a write and reads
        add(1, 1, 2, 'h99, 1, 2, 1, 2,   0, 0, 0, 0);
        add(0, 0, 0, 0,    1, 2, 0, 0,   0, 0, 0, 0);
        // hold: re_a low while raddr_a moves
        add(0, 1, 4, 'h5A, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 0, 0,    1, 4, 1, 4,   'h5A, 1, 'h5A, 1);
        add(0, 0, 0, 0,    0, 3, 1, 4,   'h5A, 1, 'h5A, 1);
        add(0, 0, 0, 0,    0, 5, 0, 1,   'h5A, 1, 'h5A, 1);
        add(0, 0, 0, 0,    0, 1, 1, 3,   'h5A, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re_a, vecs[i].raddr_a, vecs[i].re_b, vecs[i].raddr_b);
            step();
            chk($sformatf("vec%0d_rdata_a", i), 32'(rdata_a_d[0]), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_rvalid_a", i), 32'(rvalid_a_d[0]), 32'(vecs[i].va));
            chk($sformatf("vec%0d_rdata_b", i), 32'(rdata_b_d[0]), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_rvalid_b", i), 32'(rvalid_b_d[0]), 32'(vecs[i].vb));
        end

        // ZERO_REG=0 instance keeps a write to entry 0
        drive(0, 1, 0, 'hFF, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        step();
        chk("zr0_entry0_data", 32'(rdata_a_d[1]), 32'h0000_00FF);
        chk("zr0_entry0_valid", 32'(rvalid_a_d[1]), 32'h1);
        chk("zr1_entry0_data", 32'(rdata_a_d[0]), 32'h0);

        // DEPTH=6 instance ignores address 6 and keeps entry 5
        drive(0, 1, 5, 'h3E, 0, 0, 0, 0);
        step();
        drive(0, 1, 6, 'h77, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 6, 1, 5);
        step();
        chk("d6_addr6_data", 32'(rdata_a_d[2]), 32'h0);
        chk("d6_addr6_valid", 32'(rvalid_a_d[2]), 32'h0);
        chk("d6_entry5_data", 32'(rdata_b_d[2]), 32'h3E);
        chk("d8_addr6_data", 32'(rdata_a_d[0]), 32'h77);

        // random traffic against the model
        for (int n = 0; n < 300; n++) begin
            wa = int'($urandom_range(0, 7));
            drive(($urandom_range(0, 39) == 0), 1'($urandom), wa, int'($urandom_range(0, 255)),
                  1'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7)),
                  1'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7)));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
